divider: RTL and testbench

Multi-cycle 32-bit integer divider for the robin SoC. It is the inverse counterpart of the combinational ALU's multiply path and uses the same 5-bit operation code space. The CPU issues a one-cycle start and stalls on `busy`. It collects the quotient or remainder after 33 cycles, with the same `is_zero`/`is_negative` flag outputs the ALU provides.

---
 rtl/divider_if.sv | 24 ++
 rtl/divider.sv | 136 +++++++++++++
 tb/tb_divider.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Handshake and result bundle between the CPU and the divider.
// The CPU side is the master; the divider is the slave.
interface divider_if;
   logic        start;
   logic [7:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] c;
   logic        busy;
   logic        valid;
   logic        div_by_zero;
   logic        is_zero;
   logic        is_negative;

   modport master (
      output start, op, a, b,
      input  c, busy, valid, div_by_zero, is_zero, is_negative
   );

   modport slave (
      input  start, op, a, b,
      output c, busy, valid, div_by_zero, is_zero, is_negative
   );
endinterface

// File: rtl/divider.sv
// Multi-cycle 32-bit restoring divider (divu/divs/remu/rems).
// The latency is fixed: 32 iterations plus one fixup cycle.
module divider (
   input  logic     clk,
   input  logic     reset,
   divider_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      FIXUP
   } state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [32:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] mb_q;
   logic [31:0] a_q;
   logic [31:0] c_q;
   logic        sa_q;
   logic        sb_q;
   logic        remop_q;
   logic        bz_q;
   logic        busy_q;
   logic        valid_q;
   logic        dbz_q;

   logic        accept;
   logic        sgn;
   logic [31:0] ma;
   logic [31:0] mb;
   logic [32:0] rsh;
   logic [32:0] diff;
   logic [32:0] rem_d;
   logic [31:0] quo_d;
   logic [31:0] qres;
   logic [31:0] rres;
   logic [31:0] res_d;
   logic        unused_bits;

   // Operand decode, one restoring step and final sign fixup.
   always_comb begin
      sgn    = bus.op[0];
      accept = bus.start && (bus.op[4:2] == 3'b101);
      ma     = (sgn && bus.a[31]) ? -bus.a : bus.a;
      mb     = (sgn && bus.b[31]) ? -bus.b : bus.b;
      rsh    = {rem_q[31:0], quo_q[31]};
      diff   = rsh - {1'b0, mb_q};
      if (rsh >= {1'b0, mb_q}) begin
         rem_d = diff;
         quo_d = {quo_q[30:0], 1'b1};
      end else begin
         rem_d = rsh;
         quo_d = {quo_q[30:0], 1'b0};
      end
      qres = (sa_q ^ sb_q) ? -quo_q : quo_q;
      rres = sa_q ? -rem_q[31:0] : rem_q[31:0];
      if (bz_q) begin
         res_d = remop_q ? a_q : 32'hFFFF_FFFF;
      end else begin
         res_d = remop_q ? rres : qres;
      end
   end

   // The partial remainder never exceeds 32 bits after a step.
   assign unused_bits = ^{bus.op[7:5], rem_q[32]};

   // Control FSM with registered result and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         mb_q    <= '0;
         a_q     <= '0;
         c_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         remop_q <= 1'b0;
         bz_q    <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= DIVIDE;
                  cnt_q   <= 5'd31;
                  rem_q   <= '0;
                  quo_q   <= ma;
                  mb_q    <= mb;
                  a_q     <= bus.a;
                  sa_q    <= sgn & bus.a[31];
                  sb_q    <= sgn & bus.b[31];
                  remop_q <= bus.op[1];
                  bz_q    <= (bus.b == 32'd0);
                  busy_q  <= 1'b1;
                  dbz_q   <= 1'b0;
               end
            end
            DIVIDE: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd0) begin
                  state_q <= FIXUP;
               end
            end
            FIXUP: begin
               c_q     <= res_d;
               dbz_q   <= bz_q;
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.c           = c_q;
   assign bus.busy        = busy_q;
   assign bus.valid       = valid_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.is_zero     = (c_q == 32'd0);
   assign bus.is_negative = c_q[31];

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider.
// Each scenario task drives stimulus and checks inline.
module tb_divider;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   divider_if dif ();

   divider dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [7:0] DIVU = 8'd20;
   localparam logic [7:0] DIVS = 8'd21;
   localparam logic [7:0] REMU = 8'd22;
   localparam logic [7:0] REMS = 8'd23;

   // Present a one-cycle start; returns #1 after the sampling edge.
   task automatic issue(input logic [7:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      dif.start = 1'b1;
      dif.op    = op;
      dif.a     = a;
      dif.b     = b;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
   endtask

   // Wait (bounded) for valid; lat counts edges after the start edge.
   task automatic wait_valid(output int lat, output int bsy);
      lat = 0;
      bsy = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (dif.busy) bsy++;
      end while (!dif.valid && lat < 40);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dif.busy !== 1'b0 || dif.valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl busy=%b valid=%b want 0 0",
                  dif.busy, dif.valid);
      end
      checks++;
      if (dif.c !== 32'd0 || dif.div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_c c=%h dbz=%b want 0 0",
                  dif.c, dif.div_by_zero);
      end
      checks++;
      if (dif.is_zero !== 1'b1 || dif.is_negative !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags z=%b n=%b want 1 0",
                  dif.is_zero, dif.is_negative);
      end
      reset = 1'b0;
   endtask

   task automatic test_divu;
      int lat;
      int bsy;
      issue(DIVU, 32'd100, 32'd7);
      checks++;
      if (dif.busy !== 1'b1) begin
         errors++;
         $display("FAIL divu_busy0 busy=%b want 1", dif.busy);
      end
      wait_valid(lat, bsy);
      checks++;
      if (lat !== 33 || bsy !== 32) begin
         errors++;
         $display("FAIL divu_lat lat=%0d busy_cycles=%0d want 33 32",
                  lat, bsy);
      end
      checks++;
      if (dif.c !== 32'd14 || dif.is_zero !== 1'b0) begin
         errors++;
         $display("FAIL divu_c c=%h z=%b want 0000000e 0",
                  dif.c, dif.is_zero);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dif.valid !== 1'b0 || dif.c !== 32'd14) begin
         errors++;
         $display("FAIL divu_pulse valid=%b c=%h want 0 0000000e",
                  dif.valid, dif.c);
      end
      issue(REMU, 32'd100, 32'd7);
      wait_valid(lat, bsy);
      checks++;
      if (dif.c !== 32'd2 || lat !== 33) begin
         errors++;
         $display("FAIL remu c=%h lat=%0d want 00000002 33",
                  dif.c, lat);
      end
   endtask

   task automatic test_signed;
      int lat;
      int bsy;
      issue(DIVS, 32'hFFFF_FFF9, 32'd2);
      wait_valid(lat, bsy);
      checks++;
      if (dif.c !== 32'hFFFF_FFFD || dif.is_negative !== 1'b1) begin
         errors++;
         $display("FAIL divs c=%h n=%b want fffffffd 1",
                  dif.c, dif.is_negative);
      end
      issue(REMS, 32'hFFFF_FFF9, 32'd2);
      wait_valid(lat, bsy);
      checks++;
      if (dif.c !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL rems_neg c=%h want ffffffff", dif.c);
      end
      issue(REMS, 32'd7, 32'hFFFF_FFFE);
      wait_valid(lat, bsy);
      checks++;
      if (dif.c !== 32'd1) begin
         errors++;
         $display("FAIL rems_pos c=%h want 00000001", dif.c);
      end
   endtask

   task automatic test_overflow;
      int lat;
      int bsy;
      issue(DIVS, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_valid(lat, bsy);
      checks++;
      if (dif.c !== 32'h8000_0000) begin
         errors++;
         $display("FAIL ovf_div c=%h want 80000000", dif.c);
      end
      issue(REMS, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_valid(lat, bsy);
      checks++;
      if (dif.c !== 32'd0 || dif.is_zero !== 1'b1) begin
         errors++;
         $display("FAIL ovf_rem c=%h z=%b want 00000000 1",
                  dif.c, dif.is_zero);
      end
   endtask

   task automatic test_div_zero;
      int lat;
      int bsy;
      issue(DIVU, 32'd5, 32'd0);
      wait_valid(lat, bsy);
      checks++;
      if (dif.c !== 32'hFFFF_FFFF || dif.div_by_zero !== 1'b1
          || lat !== 33) begin
         errors++;
         $display("FAIL dz_divu c=%h dbz=%b lat=%0d want ffffffff 1 33",
                  dif.c, dif.div_by_zero, lat);
      end
      issue(REMS, 32'hFFFF_FFFB, 32'd0);
      checks++;
      if (dif.div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL dz_clr_on_start dbz=%b want 0", dif.div_by_zero);
      end
      wait_valid(lat, bsy);
      checks++;
      if (dif.c !== 32'hFFFF_FFFB || dif.div_by_zero !== 1'b1) begin
         errors++;
         $display("FAIL dz_rems c=%h dbz=%b want fffffffb 1",
                  dif.c, dif.div_by_zero);
      end
      issue(DIVU, 32'd100, 32'd7);
      wait_valid(lat, bsy);
      checks++;
      if (dif.div_by_zero !== 1'b0 || dif.c !== 32'd14) begin
         errors++;
         $display("FAIL dz_next dbz=%b c=%h want 0 0000000e",
                  dif.div_by_zero, dif.c);
      end
   endtask

   task automatic test_handshake;
      issue(DIVU, 32'd100, 32'd7);
      repeat (4) @(posedge clk);
      #1;
      dif.start = 1'b1;
      dif.op    = DIVS;
      dif.a     = 32'd1000;
      dif.b     = 32'd3;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      repeat (27) @(posedge clk);
      #1;
      dif.start = 1'b1;
      dif.op    = REMU;
      dif.a     = 32'd55;
      dif.b     = 32'd10;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      checks++;
      if (dif.valid !== 1'b1 || dif.c !== 32'd14) begin
         errors++;
         $display("FAIL hs_busy_start valid=%b c=%h want 1 0000000e",
                  dif.valid, dif.c);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dif.busy !== 1'b0 || dif.valid !== 1'b0) begin
         errors++;
         $display("FAIL hs_ignored busy=%b valid=%b want 0 0",
                  dif.busy, dif.valid);
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      int bsy;
      issue(DIVU, 32'd100, 32'd7);
      wait_valid(lat, bsy);
      dif.start = 1'b1;
      dif.op    = REMU;
      dif.a     = 32'd100;
      dif.b     = 32'd7;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      checks++;
      if (dif.busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept busy=%b want 1", dif.busy);
      end
      wait_valid(lat, bsy);
      checks++;
      if (lat !== 33 || dif.c !== 32'd2) begin
         errors++;
         $display("FAIL b2b_second lat=%0d c=%h want 33 00000002",
                  lat, dif.c);
      end
   endtask

   task automatic test_illegal_op;
      int seen;
      seen = 0;
      issue(8'd17, 32'd9, 32'd3);
      repeat (36) begin
         if (dif.busy || dif.valid) seen++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (seen !== 0 || dif.c !== 32'd2) begin
         errors++;
         $display("FAIL bad_op active_cycles=%0d c=%h want 0 00000002",
                  seen, dif.c);
      end
   endtask

   task automatic test_reset_mid;
      int seen;
      int lat;
      int bsy;
      seen = 0;
      issue(DIVS, 32'hFFFF_FFF9, 32'd2);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (dif.busy !== 1'b0 || dif.valid !== 1'b0 || dif.c !== 32'd0
          || dif.is_zero !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid busy=%b valid=%b c=%h z=%b want 0 0 0 1",
                  dif.busy, dif.valid, dif.c, dif.is_zero);
      end
      repeat (40) begin
         @(posedge clk);
         #1;
         if (dif.valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL rst_no_valid pulses=%0d want 0", seen);
      end
      issue(DIVU, 32'd100, 32'd7);
      wait_valid(lat, bsy);
      checks++;
      if (lat !== 33 || dif.c !== 32'd14) begin
         errors++;
         $display("FAIL rst_recover lat=%0d c=%h want 33 0000000e",
                  lat, dif.c);
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      dif.start = 1'b0;
      dif.op    = 8'd0;
      dif.a     = 32'd0;
      dif.b     = 32'd0;
      test_reset;
      test_divu;
      test_signed;
      test_overflow;
      test_div_zero;
      test_handshake;
      test_back_to_back;
      test_illegal_op;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
